// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C write-stream master: state encoding,
// per-phase bit counts and a small helper used by the SCL generator.
package i2c_master_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    DATA     = 3'd4,
    DATA_ACK = 3'd5,
    HOLD     = 3'd6
  } state_t;

  localparam int ADDR_BITS = 8;  // 7-bit address plus the write bit
  localparam int DATA_BITS = 8;
  localparam int ACK_BITS  = 1;

  // States whose bit slot drives a full SCL pulse (high in quarters 2-3).
  function automatic logic is_bit_slot(input state_t s);
    return (s == ADDR) || (s == ADDR_ACK) || (s == DATA) || (s == DATA_ACK);
  endfunction

endpackage

// File: rtl/avg4_filter.sv
// Four-tap moving average over the bytes pushed in with valid.
module avg4_filter (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] hist [4];
  logic [9:0] sum;

  // Shift the newest byte into the history on each completed byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the history is a handful of flops, not a RAM, so it is reset;
      // the average must ramp up from zero after every reset.
      for (int i = 0; i < 4; i++) hist[i] <= '0;
    end else if (valid) begin
      hist[0] <= din;
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end
  end

  assign sum  = 10'(hist[0]) + 10'(hist[1]) + 10'(hist[2]) + 10'(hist[3]);
  assign dout = sum[9:2];

endmodule

// File: rtl/i2c_master.sv
// Write-only I2C master: START, address + write bit, then an endless stream
// of data bytes, each followed by an ignored ACK slot and a HOLD slot.
module i2c_master
  import i2c_master_pkg::*;
#(
  parameter int QTR = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] slave_addr,
  input  logic [7:0] data,
  output logic       sda,
  output logic       scl,
  output logic [7:0] filtered_out,
  output logic       done
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;

  state_t        state;
  logic [QW-1:0] q_cnt;     // clocks within the current quarter
  logic [1:0]    qtr;       // quarter within the current bit slot
  logic [2:0]    bit_cnt;   // bit within the current phase
  logic [7:0]    shreg;     // outgoing bits, MSB is the next to drive
  logic [7:0]    cur_byte;  // byte currently on the wire, for the filter

  logic tick;
  logic slot_end;
  logic filt_valid;

  assign tick       = (q_cnt == QW'(QTR - 1));
  assign slot_end   = tick && (qtr == 2'd3);
  assign filt_valid = (state == DATA_ACK) && slot_end;

  // Bus sequencer: quarter/bit counters, state, and registered sda/scl/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      state    <= IDLE;
      q_cnt    <= '0;
      qtr      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      cur_byte <= '0;
      sda      <= 1'b1;
      scl      <= 1'b1;
      done     <= 1'b0;
    end else if (state == IDLE) begin
      sda   <= 1'b1;
      scl   <= 1'b1;
      q_cnt <= '0;
      qtr   <= '0;
      if (start) begin
        shreg <= {slave_addr, 1'b0};
        state <= START;
        sda   <= 1'b0;  // START: sda falls while scl is still high
      end
    end else begin
      if (tick) begin
        q_cnt <= '0;
        qtr   <= qtr + 2'd1;
      end else begin
        q_cnt <= q_cnt + QW'(1);
      end

      // Entering quarter 2: SCL rises for bit slots; START and HOLD stay low.
      if (tick && qtr == 2'd1) scl <= is_bit_slot(state);

      if (slot_end) begin
        scl <= 1'b0;
        case (state)
          START: begin
            state   <= ADDR;
            bit_cnt <= '0;
            sda     <= shreg[7];
            shreg   <= {shreg[6:0], 1'b0};
          end
          ADDR: begin
            if (bit_cnt == 3'(ADDR_BITS - 1)) begin
              state   <= ADDR_ACK;
              bit_cnt <= '0;
              sda     <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              sda     <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
            end
          end
          ADDR_ACK: begin
            if (bit_cnt == 3'(ACK_BITS - 1)) begin
              state    <= DATA;
              bit_cnt  <= '0;
              sda      <= data[7];
              shreg    <= {data[6:0], 1'b0};
              cur_byte <= data;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          DATA: begin
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              state   <= DATA_ACK;
              bit_cnt <= '0;
              sda     <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              sda     <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
            end
          end
          DATA_ACK: begin
            if (bit_cnt == 3'(ACK_BITS - 1)) begin
              state   <= HOLD;
              bit_cnt <= '0;
              done    <= 1'b1;
              sda     <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          HOLD: begin
            state    <= DATA;
            done     <= 1'b0;
            sda      <= data[7];
            shreg    <= {data[6:0], 1'b0};
            cur_byte <= data;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  avg4_filter u_filter (
    .clk   (clk),
    .rst   (rst),
    .valid (filt_valid),
    .din   (cur_byte),
    .dout  (filtered_out)
  );

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: bit-level sda capture on scl rises,
// done timing, data latching, filter ramp, reset abort and start immunity.
module tb_i2c_master;

  localparam int QTR = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] slave_addr;
  logic [7:0] data;
  logic       sda;
  logic       scl;
  logic [7:0] filtered_out;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_filt;
  } vec_t;

  vec_t vecs [8];

  i2c_master #(.QTR(QTR)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .slave_addr   (slave_addr),
    .data         (data),
    .sda          (sda),
    .scl          (scl),
    .filtered_out (filtered_out),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Wait for the next scl rising edge and return sda at that point.
  task automatic get_bit(output logic b);
    logic prev;
    bit   found;
    prev  = scl;
    found = 1'b0;
    b     = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (!prev && scl) begin
        b     = sda;
        found = 1'b1;
      end
      prev = scl;
    end
    if (!found) check("scl_rise_timeout", 0, 1);
  endtask

  task automatic get_byte(output logic [7:0] v);
    logic b;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      get_bit(b);
      v = {v[6:0], b};
    end
  endtask

  // Count clocks until done is seen high.
  task automatic wait_done_rise(output int cnt);
    bit found;
    cnt   = 0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      cnt++;
      if (done) found = 1'b1;
    end
    if (!found) check("done_rise_timeout", 0, 1);
  endtask

  // Count clocks done stays high, starting from a sample where it is high.
  task automatic count_done_high(output int cnt);
    bit fell;
    cnt  = 1;
    fell = 1'b0;
    for (int n = 0; n < 200 && !fell; n++) begin
      @(negedge clk);
      if (done) cnt++;
      else fell = 1'b1;
    end
    if (!fell) check("done_fall_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0] v;
    logic       b;
    int         cnt;
    bit         found;

    vecs[0] = '{din: 8'd100, exp_filt: 8'd25};
    vecs[1] = '{din: 8'd100, exp_filt: 8'd50};
    vecs[2] = '{din: 8'd100, exp_filt: 8'd75};
    vecs[3] = '{din: 8'd100, exp_filt: 8'd100};
    vecs[4] = '{din: 8'd50,  exp_filt: 8'd87};
    vecs[5] = '{din: 8'd50,  exp_filt: 8'd75};
    vecs[6] = '{din: 8'd50,  exp_filt: 8'd62};
    vecs[7] = '{din: 8'd50,  exp_filt: 8'd50};

    rst        = 1'b1;
    start      = 1'b0;
    slave_addr = 7'h00;
    data       = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_sda", int'(sda), 1);
    check("reset_scl", int'(scl), 1);
    check("reset_done", int'(done), 0);
    check("reset_filt", int'(filtered_out), 0);

    // First stream: address 0x50, first byte 0xAC.
    slave_addr = 7'h50;
    data       = 8'hAC;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_sda_low", int'(sda), 0);
    check("start_scl_high", int'(scl), 1);

    get_byte(v);
    check("addr_bits", int'(v), 8'hA0);
    get_bit(b);
    check("addr_ack_slot", int'(b), 1);

    get_byte(v);
    check("data0_bits", int'(v), 8'hAC);
    get_bit(b);
    check("data0_ack_slot", int'(b), 1);

    wait_done_rise(cnt);
    check("done_latency_from_ack_rise", cnt, 2 * QTR);
    check("scl_low_at_done", int'(scl), 0);
    check("filt_after_byte0", int'(filtered_out), 43);

    // New data presented while done is high must be the next byte sent.
    data = 8'h5A;
    count_done_high(cnt);
    check("done_width", cnt, 4 * QTR);

    get_byte(v);
    check("data1_bits_changed_during_done", int'(v), 8'h5A);
    get_bit(b);
    check("data1_ack_slot", int'(b), 1);
    wait_done_rise(cnt);
    check("filt_after_byte1", int'(filtered_out), 65);

    // Third byte: abort with rst during its bit-4 slot.
    data = 8'hFF;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      get_bit(b);
      v = {v[6:0], b};
    end
    check("data2_high_nibble", int'(v[3:0]), 4'hF);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (!scl) found = 1'b1;
    end
    if (!found) check("scl_fall_timeout", 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_sda", int'(sda), 1);
    check("abort_scl", int'(scl), 1);
    check("abort_done", int'(done), 0);
    check("abort_filt", int'(filtered_out), 0);

    // start together with rst must be dropped.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_rst_start_sda", int'(sda), 1);
    check("idle_after_rst_start_scl", int'(scl), 1);

    // Fresh stream: address replays, then the table-driven filter ramp.
    data  = vecs[0].din;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    get_byte(v);
    check("addr_replay_bits", int'(v), 8'hA0);
    get_bit(b);
    check("addr_replay_ack", int'(b), 1);

    for (int i = 0; i < 8; i++) begin
      get_byte(v);
      check($sformatf("vec%0d_bits", i), int'(v), int'(vecs[i].din));
      get_bit(b);
      check($sformatf("vec%0d_ack", i), int'(b), 1);
      wait_done_rise(cnt);
      check($sformatf("vec%0d_done_latency", i), cnt, 2 * QTR);
      check($sformatf("vec%0d_filt", i), int'(filtered_out), int'(vecs[i].exp_filt));
      if (i + 1 < 8) data = vecs[i + 1].din;
      if (i == 3) begin
        // Mid-stream start pulse must not disturb the sequence.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter QTR, default 2: system clocks per quarter SCL bit period, so one bit lasts 4*QTR clocks.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all logic changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse that begins a write stream; sampled only in IDLE.
REQ-005 SHALL have port slave_addr, input, 7 bits: target address, captured when start is accepted.
REQ-006 SHALL have port data, input, 8 bits: next byte to transmit, captured at each byte load.
REQ-007 SHALL have port sda, output, 1 bit: serial data, push-pull, idle high.
REQ-008 SHALL have port scl, output, 1 bit: serial clock, idle high; leaving it unconnected is legal.
REQ-009 SHALL have port filtered_out, output, 8 bits: moving average of the last 4 transmitted data bytes.
REQ-010 SHALL have port done, output, 1 bit: high for exactly 4*QTR clocks after each data byte completes.

Function
REQ-011 SHALL implement states IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, HOLD.
REQ-012 IDLE: sda=1, scl=1; start=1 -> latch slave_addr, go to START.
REQ-013 START: sda falls while scl=1, then scl falls; lasts one bit period (4*QTR clocks), then ADDR.
REQ-014 Bit timing: scl low for quarters 0-1 and high for quarters 2-3; sda changes only at the start of quarter 0.
REQ-015 ADDR: shift {slave_addr, 1'b0} (write), MSB first, 8 bits.
REQ-016 ADDR_ACK: one bit slot with sda=1 (released level); no ACK is sampled and NACK is ignored.
REQ-017 ADDR_ACK -> latch data into the shift register, go to DATA.
REQ-018 DATA: shift the latched byte MSB first, 8 bits, then DATA_ACK (same as REQ-016).
REQ-019 At DATA_ACK end: in the same clock, done rises, filtered_out updates and the state goes to HOLD.
REQ-020 HOLD: scl=0, sda=1 for 4*QTR clocks; at its end, done falls, data is latched and the state returns to DATA.
REQ-021 The stream SHALL be continuous; no STOP is generated, and only rst returns the block to IDLE.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 Filter: 4-entry history of transmitted bytes, newest shifted in on each byte completion.
REQ-024 Filter sum SHALL be 10 bits; filtered_out = sum >> 2 (truncating).
REQ-025 The filter uses zero-initialised history, so the first outputs ramp up from 0.
REQ-026 If start and rst are asserted together, rst SHALL win.

Reset
REQ-027 On rst: state=IDLE, sda=1, scl=1, done=0, filtered_out=0, filter history=0, bit and quarter counters=0.
REQ-028 rst asserted mid-byte SHALL abort immediately (asynchronously) with no STOP; the next start begins a fresh stream with the address phase.

Structure
REQ-029 State encoding and the ADDR/ACK bit counts SHALL be in a shared package i2c_master_pkg.
REQ-030 The filter SHALL be a sub-module avg4_filter: inputs clk, rst, valid, din[7:0]; output dout[7:0].
REQ-031 A single top holds the FSM and the quarter/bit counters; expected RTL size is about 150-300 lines.

Verification
REQ-032 Scenario: slave_addr=0x50, start pulse.
- Required: START condition, then sda sampled on scl rising edges = 1010_0000, then an ACK slot with sda=1.
REQ-033 Scenario: data=0xAC for the first byte.
- Required: sda bits 1,0,1,0,1,1,0,0 on successive scl rises.
- Required: done rises exactly at the end of the ACK slot and stays high for 4*QTR clocks.
REQ-034 Scenario: stream 100,100,100,100 then 50,50,50,50.
- Required: filtered_out = 25, 50, 75, 100, then 87, 75, 62, 50.
REQ-035 Scenario: change data while done=1.
- Required: the new value is the one transmitted next, because the latch happens on the falling edge of done.
REQ-036 Scenario: assert rst during the DATA bit 4 slot.
- Required: outputs immediately take their reset values (sda=1, scl=1, done=0, filtered_out=0).
- Required: a subsequent start replays the address phase.
REQ-037 Scenario: pulse start again in mid-stream.
- Required: no effect on the sda/scl sequence.
